// File: rtl/dma_arbiter_if.sv
// Bundle between the DMA arbiter, its requesters and the shared DMA engine.
// The slave modport is the arbiter's view; master is the requester/DMA side.
interface dma_arbiter_if #(
  parameter int NREQ = 3,
  parameter int OPW  = 3,
  parameter int INFW = 32
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]      req_s;
  logic [NREQ*OPW-1:0]  req_op;
  logic [NREQ*INFW-1:0] req_info1;
  logic [NREQ*INFW-1:0] req_mem_info1;
  logic [NREQ*INFW-1:0] req_info2;
  logic [NREQ*INFW-1:0] req_mem_info2;
  logic [NREQ-1:0]      req_f;
  logic [NREQ-1:0]      req_busy;
  logic [NREQ-1:0]      req_err;

  logic                 s_dma;
  logic [OPW-1:0]       dma_op;
  logic [INFW-1:0]      dma_info1;
  logic [INFW-1:0]      dma_mem_info1;
  logic [INFW-1:0]      dma_info2;
  logic [INFW-1:0]      dma_mem_info2;
  logic                 f_dma;
  logic [GW-1:0]        grant_id;
  logic [63:0]          busy_cnt;

  modport slave (
    input  req_s, req_op, req_info1, req_mem_info1, req_info2, req_mem_info2, f_dma,
    output req_f, req_busy, req_err, s_dma, dma_op, dma_info1, dma_mem_info1,
           dma_info2, dma_mem_info2, grant_id, busy_cnt
  );

  modport master (
    output req_s, req_op, req_info1, req_mem_info1, req_info2, req_mem_info2, f_dma,
    input  req_f, req_busy, req_err, s_dma, dma_op, dma_info1, dma_mem_info1,
           dma_info2, dma_mem_info2, grant_id, busy_cnt
  );
endinterface

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one DMA engine among NREQ requesters, one
// queued command per requester and a single transfer in flight.
//
// state | meaning
// IDLE  | no transfer in flight; grant next valid slot after last
// WAIT  | transfer in flight for grant_id; waiting for f_dma
module dma_arbiter #(
  parameter int NREQ = 3,
  parameter int OPW  = 3,
  parameter int INFW = 32
) (
  input  logic         clk,
  input  logic         rst,
  dma_arbiter_if.slave bus
);
  localparam int GW = $clog2(NREQ);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);

  logic [0:0]      state_q, state_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            s_dma_q, s_dma_d;
  logic [NREQ-1:0] req_f_q, req_f_d;
  logic [OPW-1:0]  dma_op_q, dma_op_d;
  logic [INFW-1:0] dma_info1_q, dma_info1_d;
  logic [INFW-1:0] dma_mem_info1_q, dma_mem_info1_d;
  logic [INFW-1:0] dma_info2_q, dma_info2_d;
  logic [INFW-1:0] dma_mem_info2_q, dma_mem_info2_d;
  logic [63:0]     busy_cnt_q, busy_cnt_d;

  logic [NREQ-1:0]            slot_vld;
  logic [NREQ-1:0][OPW-1:0]   slot_op;
  logic [NREQ-1:0][INFW-1:0]  slot_info1;
  logic [NREQ-1:0][INFW-1:0]  slot_mem_info1;
  logic [NREQ-1:0][INFW-1:0]  slot_info2;
  logic [NREQ-1:0][INFW-1:0]  slot_mem_info2;

  // Finish is only honoured once the start pulse has gone out.
  logic fin;
  assign fin = (state_q == ST_WAIT) && bus.f_dma && !s_dma_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    logic            vld_q, vld_d;
    logic            err_q, err_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [INFW-1:0] info1_q, info1_d;
    logic [INFW-1:0] mem_info1_q, mem_info1_d;
    logic [INFW-1:0] info2_q, info2_d;
    logic [INFW-1:0] mem_info2_q, mem_info2_d;

    always_comb begin
      vld_d       = vld_q;
      err_d       = err_q;
      op_d        = op_q;
      info1_d     = info1_q;
      mem_info1_d = mem_info1_q;
      info2_d     = info2_q;
      mem_info2_d = mem_info2_q;
      if (bus.req_s[g]) begin
        if (vld_q) begin
          err_d = 1'b1;
        end else begin
          vld_d       = 1'b1;
          op_d        = bus.req_op[g*OPW +: OPW];
          info1_d     = bus.req_info1[g*INFW +: INFW];
          mem_info1_d = bus.req_mem_info1[g*INFW +: INFW];
          info2_d     = bus.req_info2[g*INFW +: INFW];
          mem_info2_d = bus.req_mem_info2[g*INFW +: INFW];
        end
      end
      if (fin && (grant_q == GW'(g))) vld_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q       <= 1'b0;
        err_q       <= 1'b0;
        op_q        <= '0;
        info1_q     <= '0;
        mem_info1_q <= '0;
        info2_q     <= '0;
        mem_info2_q <= '0;
      end else begin
        vld_q       <= vld_d;
        err_q       <= err_d;
        op_q        <= op_d;
        info1_q     <= info1_d;
        mem_info1_q <= mem_info1_d;
        info2_q     <= info2_d;
        mem_info2_q <= mem_info2_d;
      end
    end

    assign slot_vld[g]       = vld_q;
    assign slot_op[g]        = op_q;
    assign slot_info1[g]     = info1_q;
    assign slot_mem_info1[g] = mem_info1_q;
    assign slot_info2[g]     = info2_q;
    assign slot_mem_info2[g] = mem_info2_q;
    assign bus.req_busy[g]   = vld_q;
    assign bus.req_err[g]    = err_q;
  end

  logic          rr_found;
  logic [GW-1:0] rr_win;
  logic [GW-1:0] rr_cand;
  int            rr_idx;

  // Search starts one past the last winner so every port gets a turn.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_cand  = '0;
    rr_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = int'(last_q) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      rr_cand = GW'(rr_idx);
      if (!rr_found && slot_vld[rr_cand]) begin
        rr_found = 1'b1;
        rr_win   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    grant_d         = grant_q;
    s_dma_d         = 1'b0;
    req_f_d         = '0;
    dma_op_d        = dma_op_q;
    dma_info1_d     = dma_info1_q;
    dma_mem_info1_d = dma_mem_info1_q;
    dma_info2_d     = dma_info2_q;
    dma_mem_info2_d = dma_mem_info2_q;
    busy_cnt_d      = busy_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          dma_op_d        = slot_op[rr_win];
          dma_info1_d     = slot_info1[rr_win];
          dma_mem_info1_d = slot_mem_info1[rr_win];
          dma_info2_d     = slot_info2[rr_win];
          dma_mem_info2_d = slot_mem_info2[rr_win];
          grant_d         = rr_win;
          last_d          = rr_win;
          s_dma_d         = 1'b1;
          state_d         = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy_cnt_d = busy_cnt_q + 64'd1;
        if (fin) begin
          req_f_d = NREQ'(1) << grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      last_q          <= LAST_RST;
      grant_q         <= '0;
      s_dma_q         <= 1'b0;
      req_f_q         <= '0;
      dma_op_q        <= '0;
      dma_info1_q     <= '0;
      dma_mem_info1_q <= '0;
      dma_info2_q     <= '0;
      dma_mem_info2_q <= '0;
      busy_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      grant_q         <= grant_d;
      s_dma_q         <= s_dma_d;
      req_f_q         <= req_f_d;
      dma_op_q        <= dma_op_d;
      dma_info1_q     <= dma_info1_d;
      dma_mem_info1_q <= dma_mem_info1_d;
      dma_info2_q     <= dma_info2_d;
      dma_mem_info2_q <= dma_mem_info2_d;
      busy_cnt_q      <= busy_cnt_d;
    end
  end

  assign bus.s_dma         = s_dma_q;
  assign bus.req_f         = req_f_q;
  assign bus.dma_op        = dma_op_q;
  assign bus.dma_info1     = dma_info1_q;
  assign bus.dma_mem_info1 = dma_mem_info1_q;
  assign bus.dma_info2     = dma_info2_q;
  assign bus.dma_mem_info2 = dma_mem_info2_q;
  assign bus.grant_id      = grant_q;
  assign bus.busy_cnt      = busy_cnt_q;
endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: inputs driven and outputs sampled on the
// falling edge, so each negedge sees the state registered at the prior rise.
module tb_dma_arbiter;
  localparam int NREQ = 3;
  localparam int OPW  = 3;
  localparam int INFW = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  dma_arbiter_if #(.NREQ(NREQ), .OPW(OPW), .INFW(INFW)) bus ();

  dma_arbiter #(.NREQ(NREQ), .OPW(OPW), .INFW(INFW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_in();
    bus.req_s         = '0;
    bus.req_op        = '0;
    bus.req_info1     = '0;
    bus.req_mem_info1 = '0;
    bus.req_info2     = '0;
    bus.req_mem_info2 = '0;
    bus.f_dma         = 1'b0;
  endtask

  task automatic pulse_req(input int i, input logic [OPW-1:0] op, input logic [INFW-1:0] i1,
                           input logic [INFW-1:0] m1, input logic [INFW-1:0] i2,
                           input logic [INFW-1:0] m2);
    bus.req_s[i]                       = 1'b1;
    bus.req_op[i*OPW +: OPW]           = op;
    bus.req_info1[i*INFW +: INFW]      = i1;
    bus.req_mem_info1[i*INFW +: INFW]  = m1;
    bus.req_info2[i*INFW +: INFW]      = i2;
    bus.req_mem_info2[i*INFW +: INFW]  = m2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_dma"}, 64'(bus.s_dma), 64'd0);
    chk({tag, "_op"}, 64'(bus.dma_op), 64'd0);
    chk({tag, "_info1"}, 64'(bus.dma_info1), 64'd0);
    chk({tag, "_mem1"}, 64'(bus.dma_mem_info1), 64'd0);
    chk({tag, "_info2"}, 64'(bus.dma_info2), 64'd0);
    chk({tag, "_mem2"}, 64'(bus.dma_mem_info2), 64'd0);
    chk({tag, "_req_f"}, 64'(bus.req_f), 64'd0);
    chk({tag, "_busy"}, 64'(bus.req_busy), 64'd0);
    chk({tag, "_err"}, 64'(bus.req_err), 64'd0);
    chk({tag, "_gid"}, 64'(bus.grant_id), 64'd0);
    chk({tag, "_bcnt"}, bus.busy_cnt, 64'd0);
  endtask

  // Bounded wait for the next start pulse; returns the granted id.
  task automatic wait_sdma(input string tag, output logic [1:0] gid);
    int n;
    n = 0;
    while (bus.s_dma !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 64'(bus.s_dma), 64'd1);
    gid = bus.grant_id;
  endtask

  // From the s_dma cycle: f_dma two cycles later, return in the req_f cycle.
  task automatic finish_xfer(input string tag, input int w);
    tick();
    tick();
    bus.f_dma = 1'b1;
    tick();
    bus.f_dma = 1'b0;
    chk(tag, 64'(bus.req_f), 64'd1 << w);
  endtask

  logic [1:0]  gid;
  logic [63:0] bc;
  int          cnt;
  int          bad;

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();

    // single request on port 1
    pulse_req(1, 3'd2, 32'd5, 32'h100, 32'd7, 32'h200);
    tick();
    bus.req_s = '0;
    chk("t1_busy_c1", 64'(bus.req_busy), 64'b010);
    chk("t1_sdma_c1", 64'(bus.s_dma), 64'd0);
    tick();
    chk("t1_sdma_c2", 64'(bus.s_dma), 64'd1);
    chk("t1_op", 64'(bus.dma_op), 64'd2);
    chk("t1_info1", 64'(bus.dma_info1), 64'd5);
    chk("t1_mem1", 64'(bus.dma_mem_info1), 64'h100);
    chk("t1_info2", 64'(bus.dma_info2), 64'd7);
    chk("t1_mem2", 64'(bus.dma_mem_info2), 64'h200);
    chk("t1_gid", 64'(bus.grant_id), 64'd1);
    tick();
    chk("t1_sdma_c3", 64'(bus.s_dma), 64'd0);
    repeat (9) tick();
    chk("t1_bcnt_at_f", bus.busy_cnt, 64'd10);
    chk("t1_no_f_early", 64'(bus.req_f), 64'd0);
    bus.f_dma = 1'b1;
    tick();
    bus.f_dma = 1'b0;
    chk("t1_req_f", 64'(bus.req_f), 64'b010);
    chk("t1_busy_clr", 64'(bus.req_busy), 64'd0);
    chk("t1_bcnt_after", bus.busy_cnt, 64'd11);
    tick();
    chk("t1_req_f_one", 64'(bus.req_f), 64'd0);

    // round robin from reset, port 0 re-requests in its req_f cycle
    do_reset();
    for (int i = 0; i < NREQ; i++)
      pulse_req(i, 3'(i + 1), 32'h10 + 32'(i), 32'h1000 + 32'(i), 32'd0, 32'd0);
    tick();
    bus.req_s = '0;
    chk("rr_busy_all", 64'(bus.req_busy), 64'b111);
    wait_sdma("rr_a", gid);
    chk("rr_a_gid", 64'(gid), 64'd0);
    chk("rr_a_op", 64'(bus.dma_op), 64'd1);
    chk("rr_a_info1", 64'(bus.dma_info1), 64'h10);
    finish_xfer("rr_a_f", 0);
    pulse_req(0, 3'd5, 32'h50, 32'h5000, 32'd0, 32'd0);
    tick();
    bus.req_s = '0;
    chk("rr_rereq_busy", 64'(bus.req_busy), 64'b111);
    chk("rr_rereq_err", 64'(bus.req_err), 64'd0);
    wait_sdma("rr_b", gid);
    chk("rr_b_gid", 64'(gid), 64'd1);
    chk("rr_b_op", 64'(bus.dma_op), 64'd2);
    finish_xfer("rr_b_f", 1);
    wait_sdma("rr_c", gid);
    chk("rr_c_gid", 64'(gid), 64'd2);
    chk("rr_c_op", 64'(bus.dma_op), 64'd3);
    finish_xfer("rr_c_f", 2);
    wait_sdma("rr_d", gid);
    chk("rr_d_gid", 64'(gid), 64'd0);
    chk("rr_d_op", 64'(bus.dma_op), 64'd5);
    chk("rr_d_info1", 64'(bus.dma_info1), 64'h50);
    finish_xfer("rr_d_f", 0);
    tick();
    chk("rr_end_busy", 64'(bus.req_busy), 64'd0);

    // duplicate request on port 2 while its slot is occupied
    pulse_req(2, 3'd6, 32'hAA, 32'hA000, 32'd1, 32'd2);
    tick();
    bus.req_s = '0;
    tick();
    chk("dup_sdma", 64'(bus.s_dma), 64'd1);
    chk("dup_gid", 64'(bus.grant_id), 64'd2);
    tick();
    pulse_req(2, 3'd1, 32'hBB, 32'hB000, 32'd3, 32'd4);
    tick();
    bus.req_s = '0;
    chk("dup_err", 64'(bus.req_err), 64'b100);
    chk("dup_op_kept", 64'(bus.dma_op), 64'd6);
    chk("dup_info1_kept", 64'(bus.dma_info1), 64'hAA);
    chk("dup_mem1_kept", 64'(bus.dma_mem_info1), 64'hA000);
    bus.f_dma = 1'b1;
    tick();
    bus.f_dma = 1'b0;
    chk("dup_req_f", 64'(bus.req_f), 64'b100);
    cnt = 0;
    repeat (10) begin
      if (bus.s_dma === 1'b1) cnt++;
      tick();
    end
    chk("dup_extra_sdma", 64'(cnt), 64'd0);
    chk("dup_busy_end", 64'(bus.req_busy), 64'd0);
    chk("dup_err_sticky", 64'(bus.req_err), 64'b100);

    // spurious finish in IDLE and coincident with s_dma
    bc = bus.busy_cnt;
    bus.f_dma = 1'b1;
    tick();
    bus.f_dma = 1'b0;
    chk("sp_idle_req_f", 64'(bus.req_f), 64'd0);
    chk("sp_idle_sdma", 64'(bus.s_dma), 64'd0);
    chk("sp_idle_bcnt", bus.busy_cnt, bc);
    tick();
    chk("sp_idle_req_f2", 64'(bus.req_f), 64'd0);
    pulse_req(0, 3'd3, 32'h33, 32'h3300, 32'd0, 32'd0);
    tick();
    bus.req_s = '0;
    tick();
    chk("sp_co_sdma", 64'(bus.s_dma), 64'd1);
    bus.f_dma = 1'b1;
    tick();
    bus.f_dma = 1'b0;
    chk("sp_co_req_f", 64'(bus.req_f), 64'd0);
    chk("sp_co_busy", 64'(bus.req_busy), 64'b001);
    chk("sp_co_sdma_low", 64'(bus.s_dma), 64'd0);
    repeat (3) tick();
    chk("sp_co_waiting", 64'(bus.req_busy), 64'b001);
    chk("sp_co_req_f2", 64'(bus.req_f), 64'd0);
    bus.f_dma = 1'b1;
    tick();
    bus.f_dma = 1'b0;
    chk("sp_co_fin", 64'(bus.req_f), 64'b001);

    // reset mid-WAIT, then a stale f_dma
    tick();
    pulse_req(1, 3'd7, 32'h77, 32'h7700, 32'h78, 32'h7800);
    tick();
    bus.req_s = '0;
    tick();
    chk("rw_sdma", 64'(bus.s_dma), 64'd1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("rw");
    rst = 1'b0;
    tick();
    bus.f_dma = 1'b1;
    tick();
    bus.f_dma = 1'b0;
    chk("rw_stale_req_f", 64'(bus.req_f), 64'd0);
    tick();
    chk("rw_stale_req_f2", 64'(bus.req_f), 64'd0);
    chk("rw_sdma_after", 64'(bus.s_dma), 64'd0);
    chk("rw_bcnt_after", bus.busy_cnt, 64'd0);

    // descriptor hold after completion
    pulse_req(2, 3'd4, 32'h44, 32'h4400, 32'h45, 32'h4500);
    tick();
    bus.req_s = '0;
    wait_sdma("hold", gid);
    chk("hold_gid", 64'(gid), 64'd2);
    finish_xfer("hold_f", 2);
    cnt = 0;
    bad = 0;
    repeat (20) begin
      tick();
      if (bus.s_dma !== 1'b0) cnt++;
      if (bus.dma_op !== 3'd4 || bus.dma_info1 !== 32'h44 || bus.dma_mem_info1 !== 32'h4400 ||
          bus.dma_info2 !== 32'h45 || bus.dma_mem_info2 !== 32'h4500) bad++;
    end
    chk("hold_sdma", 64'(cnt), 64'd0);
    chk("hold_fields", 64'(bad), 64'd0);
    chk("hold_op", 64'(bus.dma_op), 64'd4);
    chk("hold_mem2", 64'(bus.dma_mem_info2), 64'h4500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
